fifo_sp: RTL
============

Name: fifo_sp

Overview:
- Parametrised synchronous FIFO; successor of the fixed 9-bit fifo.
- Per-cycle mode select `pin`:
  - pin=1: parallel word in/out.
  - pin=0: serial bit-stream in on `sin`, bit-stream out on `pout`.
- Adds explicit push/pop handshake, full/empty/count flags and overflow/underflow pulses.
- Sits between the datapath and the serial test/debug interface.

Parameters:
- WIDTH, 9: data word width in bits (>=2).
- DEPTH, 16: number of words; power of two, >=2.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- pin  input  1  mode: 1 = parallel, 0 = serial.
- sin  input  1  serial data in, LSB first.
- din  input  WIDTH  parallel write data.
- wr_en  input  1  push request (parallel: one word; serial: one bit).
- rd_en  input  1  pop request (parallel: one word; serial: one bit).
- dout  output  WIDTH  registered parallel read data.
- pout  output  1  registered serial read bit.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- count  output  clog2(DEPTH)+1  stored word count.
- overflow  output  1  one-cycle pulse: a word push was rejected.
- underflow  output  1  one-cycle pulse: a pop was rejected.

Behaviour:
- Reset (sync, active-high):
  - Pointers and count are cleared; empty=1, full=0.
  - dout=0, pout=0, overflow=0, underflow=0.
  - Serial bit counters (wbit, rbit) and the deserialiser are cleared.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all words and partial words on that edge.
  - Reset has priority over every other input.
- Storage:
  - mem[DEPTH] of WIDTH bits.
  - wr_ptr and rd_ptr are clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - full, empty and count are registered and consistent in the same cycle.
- Word push event:
  - Accepted when not full, or when full and a word pop occurs on the same edge.
  - Otherwise the word is dropped and overflow pulses for one cycle.
- Word pop event:
  - Accepted when not empty.
  - When empty, a pop is rejected and underflow pulses, even if a push is accepted on the same edge; no read-through.
- Simultaneous accepted push and pop: count is unchanged and both pointers advance.
- Parallel mode (pin=1):
  - wr_en=1 is a word push of din.
  - rd_en=1 is a word pop; dout <= mem[rd_ptr] on that edge, so data is valid the cycle after rd_en (1-cycle latency).
  - dout holds its value otherwise.
- Serial write (pin=0):
  - Each wr_en cycle shifts sin into the deserialiser at bit position wbit, then wbit increments.
  - On the cycle where wbit==WIDTH-1, the assembled word (including that bit) is pushed on that edge and wbit returns to 0.
  - The overflow rule applies to that push.
- Serial read (pin=0):
  - Each rd_en cycle with !empty: pout <= mem[rd_ptr][rbit], then rbit increments.
  - When rbit==WIDTH-1, the word is popped on that edge and rbit returns to 0.
  - rd_en while empty: pout holds its value, underflow pulses, rbit is unchanged.
- Mode change:
  - Any edge where pin differs from its previous registered value clears wbit and rbit and discards the partial word.
  - Request inputs on that edge are still processed, in the new mode, from bit 0.
- din is ignored in serial mode; sin is ignored in parallel mode.

Optional Feature:
- Macro: FIFO_SP_SCAN_EN.
- When defined:
  - Adds ports scan_en (in, 1), scan_in (in, 1) and scan_out (out, 1).
  - With scan_en=1, all state registers shift one position per clock as a single chain.
  - Chain order: scan_in -> wr_ptr -> rd_ptr -> count -> wbit -> rbit -> deserialiser -> mem[0..DEPTH-1] (LSB first) -> dout -> pout -> scan_out.
  - Functional updates are suppressed while scan_en=1.
  - reset still overrides scan.
- When undefined: no scan ports, and behaviour is exactly as above.

Decomposition:
- Package fifo_sp_pkg holds:
  - MODE_SERIAL=0 and MODE_PARALLEL=1 constants.
  - A clog2 constant function.
  - The pointer-width localparam formula.
- One sub-module, fifo_sp_ser: a bit counter plus shift register, instantiated once for write deserialisation and once for read bit-indexing. It outputs a word-complete strobe.

Test Plan:
- Reset, then parallel mode, WIDTH=9 DEPTH=16: push 0x1A5, 0x0F3, then pop twice -> dout=0x1A5 then 0x0F3 each one cycle after rd_en; empty=1 and count=0 at the end.
- Push 16 words, then a 17th -> full=1, count=16, overflow pulses one cycle, and a later pop returns the 1st word. Push+pop while full -> count stays 16.
- Pop while empty, with a simultaneous push -> underflow pulses, count=1, dout unchanged.
- Serial mode: shift 9 bits of 0x155 LSB first with wr_en -> count becomes 1 on the 9th edge. Read 9 rd_en cycles -> pout sequence 1,0,1,0,1,0,1,0,1, and empty=1 after the 9th.
- Serial write of 5 bits, toggle pin to 1 then back to 0, then write 9 bits of 0x003 -> only 0x003 is stored (count=1). Assert reset mid-stream -> all flags return to reset values.
- With FIFO_SP_SCAN_EN: load a known state, shift out the full chain with scan_en=1 -> scan_out stream matches the state in chain order, and count does not change while shifting.

Source files
------------

// File: rtl/fifo_sp_pkg.sv
// Shared constants and width helpers for the fifo_sp parallel/serial FIFO.
package fifo_sp_pkg;

   localparam logic MODE_SERIAL   = 1'b0;
   localparam logic MODE_PARALLEL = 1'b1;

   function automatic int clog2(input int value);
      int result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) result++;
      return result;
   endfunction

   // Pointers index DEPTH words; the stored-word count needs one more bit.
   function automatic int ptrWidth(input int depth);
      return clog2(depth);
   endfunction

endpackage

// File: rtl/fifo_sp_ser.sv
// Bit counter plus shift register: deserialises a bit stream (STORE=1) or
// produces a one-hot bit index (STORE=0, base word held at zero).
module fifo_sp_ser
   import fifo_sp_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter bit STORE = 1'b1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    step,
   input  logic                    bitIn,
`ifdef FIFO_SP_SCAN_EN
   input  logic                    load,
   input  logic [clog2(WIDTH)-1:0] loadCnt,
   input  logic [WIDTH-1:0]        loadReg,
   output logic [clog2(WIDTH)-1:0] cnt,
   output logic [WIDTH-1:0]        held,
`endif
   output logic [WIDTH-1:0]        word,
   output logic                    done
);

   localparam int BW = clog2(WIDTH);
   localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

   logic [BW-1:0]    bitCnt;
   logic [BW-1:0]    effCnt;
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] effBase;
   logic [WIDTH-1:0] oneHot;

   // A clear (mode change) restarts from bit 0 on the same edge it occurs.
   assign effCnt  = clear ? '0 : bitCnt;
   assign effBase = clear ? '0 : base;
   assign oneHot  = {{(WIDTH-1){1'b0}}, 1'b1} << effCnt;
   assign word    = bitIn ? (effBase | oneHot) : (effBase & ~oneHot);
   assign done    = step && (effCnt == LAST);

`ifdef FIFO_SP_SCAN_EN
   assign cnt  = bitCnt;
   assign held = base;
`endif

   always_ff @(posedge clock) begin
      if (reset)
         bitCnt <= '0;
`ifdef FIFO_SP_SCAN_EN
      else if (load)
         bitCnt <= loadCnt;
`endif
      else if (step)
         bitCnt <= done ? '0 : effCnt + BW'(1);
      else
         bitCnt <= effCnt;
   end

   if (STORE) begin : gStore
      logic [WIDTH-1:0] shiftReg;

      always_ff @(posedge clock) begin
         if (reset)
            shiftReg <= '0;
`ifdef FIFO_SP_SCAN_EN
         else if (load)
            shiftReg <= loadReg;
`endif
         else if (step)
            shiftReg <= done ? '0 : word;
         else if (clear)
            shiftReg <= '0;
      end

      assign base = shiftReg;
   end else begin : gNoStore
      assign base = '0;
`ifdef FIFO_SP_SCAN_EN
      logic unusedLoad;
      assign unusedLoad = ^loadReg;
`endif
   end

endmodule

// File: rtl/fifo_sp.sv
// Parametrised FIFO with per-cycle parallel/serial access mode.
// Define FIFO_SP_SCAN_EN to add a full-state scan chain (scan_en/scan_in/scan_out).
module fifo_sp
   import fifo_sp_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     pin,
   input  logic                     sin,
   input  logic [WIDTH-1:0]         din,
   input  logic                     wr_en,
   input  logic                     rd_en,
`ifdef FIFO_SP_SCAN_EN
   input  logic                     scan_en,
   input  logic                     scan_in,
   output logic                     scan_out,
`endif
   output logic [WIDTH-1:0]         dout,
   output logic                     pout,
   output logic                     full,
   output logic                     empty,
   output logic [ptrWidth(DEPTH):0] count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int PW = ptrWidth(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wrPtr;
   logic [PW-1:0]    rdPtr;
   logic             pinQ;

   logic             modeChange;
   logic             wrStep;
   logic             rdStep;
   logic             wrDone;
   logic             rdDone;
   logic [WIDTH-1:0] wrWord;
   logic [WIDTH-1:0] rdMask;
   logic [WIDTH-1:0] rdWord;
   logic [WIDTH-1:0] pushData;
   logic             pushReq;
   logic             popReq;
   logic             pushOk;
   logic             popOk;
   logic [CW-1:0]    nextCount;

   assign modeChange = (pin != pinQ);
   assign wrStep     = (pin == MODE_SERIAL) && wr_en;
   assign rdStep     = (pin == MODE_SERIAL) && rd_en && !empty;
   assign rdWord     = mem[rdPtr];
   assign pushReq    = (pin == MODE_PARALLEL) ? wr_en : wrDone;
   assign popReq     = (pin == MODE_PARALLEL) ? rd_en : rdDone;
   assign pushData   = (pin == MODE_PARALLEL) ? din : wrWord;
   // A pop frees the slot a same-edge push needs; an empty FIFO never reads through.
   assign popOk      = popReq && !empty;
   assign pushOk     = pushReq && (!full || popOk);
   assign nextCount  = count + CW'(pushOk) - CW'(popOk);

`ifdef FIFO_SP_SCAN_EN
   localparam int BW     = clog2(WIDTH);
   localparam int O_RD   = PW;
   localparam int O_CNT  = 2 * PW;
   localparam int O_WB   = O_CNT + CW;
   localparam int O_RB   = O_WB + BW;
   localparam int O_DS   = O_RB + BW;
   localparam int O_MEM  = O_DS + WIDTH;
   localparam int O_DOUT = O_MEM + DEPTH * WIDTH;
   localparam int O_POUT = O_DOUT + WIDTH;
   localparam int N      = O_POUT + 1;

   logic [BW-1:0]          wbit;
   logic [BW-1:0]          rbit;
   logic [WIDTH-1:0]       deser;
   logic [WIDTH-1:0]       unusedRdHeld;
   logic [DEPTH*WIDTH-1:0] memFlat;
   logic [N-1:0]           chainCur;
   logic [N-1:0]           chainNext;

   always_comb begin
      memFlat = '0;
      for (int i = 0; i < DEPTH; i++) memFlat[i*WIDTH +: WIDTH] = mem[i];
   end

   // Bit 0 sits next to scan_in, so each field shifts LSB first toward scan_out.
   assign chainCur  = {pout, dout, memFlat, deser, rbit, wbit, count, rdPtr, wrPtr};
   assign chainNext = {chainCur[N-2:0], scan_in};
   assign scan_out  = chainCur[N-1];
`endif

   fifo_sp_ser #(.WIDTH(WIDTH), .STORE(1'b1)) wrSer (
      .clock   (clock),
      .reset   (reset),
      .clear   (modeChange),
      .step    (wrStep),
      .bitIn   (sin),
`ifdef FIFO_SP_SCAN_EN
      .load    (scan_en),
      .loadCnt (chainNext[O_WB +: BW]),
      .loadReg (chainNext[O_DS +: WIDTH]),
      .cnt     (wbit),
      .held    (deser),
`endif
      .word    (wrWord),
      .done    (wrDone)
   );

   fifo_sp_ser #(.WIDTH(WIDTH), .STORE(1'b0)) rdSer (
      .clock   (clock),
      .reset   (reset),
      .clear   (modeChange),
      .step    (rdStep),
      .bitIn   (1'b1),
`ifdef FIFO_SP_SCAN_EN
      .load    (scan_en),
      .loadCnt (chainNext[O_RB +: BW]),
      .loadReg ('0),
      .cnt     (rbit),
      .held    (unusedRdHeld),
`endif
      .word    (rdMask),
      .done    (rdDone)
   );

   always_ff @(posedge clock) begin
`ifdef FIFO_SP_SCAN_EN
      if (!reset && scan_en) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= chainNext[O_MEM + i*WIDTH +: WIDTH];
      end else
`endif
      if (!reset && pushOk)
         mem[wrPtr] <= pushData;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         count     <= '0;
         full      <= 1'b0;
         empty     <= 1'b1;
         dout      <= '0;
         pout      <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         pinQ      <= pin;
      end
`ifdef FIFO_SP_SCAN_EN
      else if (scan_en) begin
         wrPtr     <= chainNext[0 +: PW];
         rdPtr     <= chainNext[O_RD +: PW];
         count     <= chainNext[O_CNT +: CW];
         full      <= (chainNext[O_CNT +: CW] == DEPTH_C);
         empty     <= (chainNext[O_CNT +: CW] == '0);
         dout      <= chainNext[O_DOUT +: WIDTH];
         pout      <= chainNext[O_POUT];
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end
`endif
      else begin
         pinQ      <= pin;
         if (pushOk) wrPtr <= wrPtr + PW'(1);
         if (popOk)  rdPtr <= rdPtr + PW'(1);
         count     <= nextCount;
         full      <= (nextCount == DEPTH_C);
         empty     <= (nextCount == '0);
         overflow  <= pushReq && !pushOk;
         underflow <= rd_en && empty;
         if ((pin == MODE_PARALLEL) && popOk) dout <= rdWord;
         if (rdStep) pout <= |(rdWord & rdMask);
      end
   end

endmodule
